// File: rtl/i_tree_pkg.sv
// Shared types, default parameters and tree helpers for the isolation-tree evaluator.
package i_tree_pkg;

  localparam int unsigned DATA_W_DEF     = 8;
  localparam int unsigned NUM_CH_DEF     = 4;
  localparam int unsigned FIFO_DEPTH_DEF = 8;
  localparam int unsigned TREE_DEPTH_DEF = 4;
  localparam int unsigned ANOM_LEN_DEF   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_DONE = 2'd2
  } eval_state_e;

  // Heap-ordered child: left = 2n+1, right = 2n+2.
  function automatic int unsigned child_idx(input int unsigned node, input logic go_right);
    return 2 * node + 1 + 32'(go_right);
  endfunction

endpackage

// File: rtl/i_tree_fifo.sv
// Synchronous FIFO; a pushed entry becomes readable the cycle after the push.
module i_tree_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             full_nxt_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] level;
  logic [CNT_W-1:0] level_nxt;
  logic             push_ok;
  logic             pop_ok;

  always_comb begin
    push_ok    = push && !full;
    pop_ok     = pop && !empty;
    level_nxt  = level + CNT_W'(push_ok) - CNT_W'(pop_ok);
    full_nxt_c = (level_nxt == CNT_W'(DEPTH));
  end

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_nxt;
      full  <= full_nxt_c;
      empty <= (level_nxt == '0);
    end
  end

endmodule

// File: rtl/i_tree_multich.sv
// Multi-channel isolation-tree scorer: buffers samples, walks a configurable tree
// one node per cycle and flags samples whose path is short.
module i_tree_multich
  import i_tree_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned NUM_CH     = NUM_CH_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned TREE_DEPTH = TREE_DEPTH_DEF,
  parameter int unsigned ANOM_LEN   = ANOM_LEN_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [$clog2(NUM_CH)-1:0]     in_ch,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          cfg_we,
  input  logic [TREE_DEPTH-1:0]         cfg_addr,
  input  logic [DATA_W-1:0]             cfg_thr,
  input  logic                          cfg_leaf,
  output logic                          cfg_err,
  output logic                          res_valid,
  output logic [$clog2(NUM_CH)-1:0]     res_ch,
  output logic [$clog2(TREE_DEPTH)-1:0] res_path_len,
  output logic                          res_anomaly,
  output logic [NUM_CH-1:0]             anomaly_flags,
  input  logic [NUM_CH-1:0]             flags_clear,
  output logic                          busy
);

  localparam int unsigned CH_W   = $clog2(NUM_CH);
  localparam int unsigned LEN_W  = $clog2(TREE_DEPTH);
  localparam int unsigned NODE_W = TREE_DEPTH;
  localparam int unsigned NODES  = (2 ** TREE_DEPTH) - 1;
  localparam int unsigned TBL    = 2 ** TREE_DEPTH;
  localparam int unsigned FIFO_W = CH_W + DATA_W;

  eval_state_e        state, state_nxt;
  logic [NODE_W-1:0]  node, node_nxt;
  logic [LEN_W-1:0]   len, len_nxt;
  logic [DATA_W-1:0]  smp, smp_nxt;
  logic [CH_W-1:0]    ch, ch_nxt;
  logic               go_right;
  logic               fifo_pop_c;
  logic               push;
  logic [FIFO_W-1:0]  fifo_rd_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_full_nxt_c;
  logic               cfg_ok;
  logic [NUM_CH-1:0]  set_vec;

  logic [DATA_W-1:0]  thr [TBL];
  logic [TBL-1:0]     leaf;

  assign push = in_valid && in_ready && !fifo_full;

  i_tree_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .wr_data    ({in_ch, in_data}),
    .pop        (fifo_pop_c),
    .rd_data    (fifo_rd_data),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .full_nxt_c (fifo_full_nxt_c)
  );

  // Evaluator next-state: depth is tracked by len, which equals the current node level.
  always_comb begin
    state_nxt  = state;
    node_nxt   = node;
    len_nxt    = len;
    smp_nxt    = smp;
    ch_nxt     = ch;
    fifo_pop_c = 1'b0;
    go_right   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop_c       = 1'b1;
          {ch_nxt, smp_nxt} = fifo_rd_data;
          node_nxt         = '0;
          len_nxt          = '0;
          state_nxt        = ST_WALK;
        end
      end
      ST_WALK: begin
        if (leaf[node] || (len == LEN_W'(TREE_DEPTH - 1))) begin
          state_nxt = ST_DONE;
        end else begin
          go_right = !(smp < thr[node]);
          node_nxt = NODE_W'(child_idx(32'(node), go_right));
          len_nxt  = len + LEN_W'(1);
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_ok  = cfg_we && !busy && (cfg_addr < NODE_W'(NODES));
    set_vec = '0;
    if (res_valid && res_anomaly) set_vec = NUM_CH'(1) << res_ch;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      node  <= '0;
      len   <= '0;
      smp   <= '0;
      ch    <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      node  <= node_nxt;
      len   <= len_nxt;
      smp   <= smp_nxt;
      ch    <= ch_nxt;
      busy  <= (state_nxt != ST_IDLE);
    end
  end

  // Result strobe lags DONE by one edge; set beats a coincident clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready      <= 1'b0;
      cfg_err       <= 1'b0;
      res_valid     <= 1'b0;
      res_ch        <= '0;
      res_path_len  <= '0;
      res_anomaly   <= 1'b0;
      anomaly_flags <= '0;
    end else begin
      in_ready      <= !fifo_full_nxt_c;
      cfg_err       <= cfg_we && !cfg_ok;
      res_valid     <= (state == ST_DONE);
      if (state == ST_DONE) begin
        res_ch       <= ch;
        res_path_len <= len;
        res_anomaly  <= (32'(len) < ANOM_LEN);
      end
      anomaly_flags <= (anomaly_flags & ~flags_clear) | set_vec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < TBL; i++) thr[i] <= '0;
      leaf <= '0;
    end else if (cfg_ok) begin
      thr[cfg_addr]  <= cfg_thr;
      leaf[cfg_addr] <= cfg_leaf;
    end
  end

endmodule

// File: tb/tb_i_tree_multich.sv
// Self-checking bench for i_tree_multich against a path-length reference model.
module tb_i_tree_multich;

  localparam int NUM_NODES = 15;
  localparam int TDEPTH    = 4;
  localparam int ALEN      = 2;
  localparam int FDEPTH    = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_ch = '0;
  logic [7:0] in_data = '0;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [7:0] cfg_thr = '0;
  logic       cfg_leaf = 1'b0;
  logic       cfg_err;
  logic       res_valid;
  logic [1:0] res_ch;
  logic [1:0] res_path_len;
  logic       res_anomaly;
  logic [3:0] anomaly_flags;
  logic [3:0] flags_clear = '0;
  logic       busy;

  i_tree_multich dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_ch         (in_ch),
    .in_data       (in_data),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_thr       (cfg_thr),
    .cfg_leaf      (cfg_leaf),
    .cfg_err       (cfg_err),
    .res_valid     (res_valid),
    .res_ch        (res_ch),
    .res_path_len  (res_path_len),
    .res_anomaly   (res_anomaly),
    .anomaly_flags (anomaly_flags),
    .flags_clear   (flags_clear),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int len;
    bit anom;
    int cyc;
  } rec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic [7:0] m_thr [NUM_NODES];
  bit         m_leaf [NUM_NODES];
  rec_t exp_q[$];
  rec_t got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rec_t r;
    if (res_valid === 1'b1) begin
      r.ch = int'(res_ch); r.len = int'(res_path_len); r.anom = res_anomaly; r.cyc = cyc;
      got_q.push_back(r);
    end
  end

  // Reference: walk the configured tree with plain arithmetic.
  function automatic int model_len(input logic [7:0] d);
    int n = 0;
    int l = 0;
    while (!m_leaf[n] && l < TDEPTH - 1) begin
      n = (d < m_thr[n]) ? 2 * n + 1 : 2 * n + 2;
      l++;
    end
    return l;
  endfunction

  task automatic step();
    @(posedge clk); @(negedge clk); #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_NODES; i++) begin m_thr[i] = '0; m_leaf[i] = 1'b0; end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; flags_clear = '0;
    step(); step();
    reset = 1'b0;
    step();
    model_clear();
  endtask

  task automatic drive(input bit v, input int ch, input int d);
    rec_t r;
    bit acc;
    in_valid = v; in_ch = 2'(ch); in_data = 8'(d);
    acc = v && (in_ready === 1'b1);
    step();
    in_valid = 1'b0;
    if (acc) begin
      r.ch = ch; r.len = model_len(8'(d)); r.anom = (r.len < ALEN); r.cyc = cyc;
      exp_q.push_back(r);
    end
  endtask

  task automatic cfg_write(input int a, input int t, input bit l);
    cfg_we = 1'b1; cfg_addr = 4'(a); cfg_thr = 8'(t); cfg_leaf = l;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic drain(input int max);
    for (int k = 0; k < max && got_q.size() < exp_q.size(); k++) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    n_cmp++;
    if ({in_ready, res_valid, res_ch, res_path_len, res_anomaly, cfg_err, busy} !== 9'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 000000000",
               {in_ready, res_valid, res_ch, res_path_len, res_anomaly, cfg_err, busy});
    end
    n_cmp++;
    if (anomaly_flags !== 4'b0) begin
      n_err++; $display("FAIL reset_flags: got %b want 0000", anomaly_flags);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready_after: got %b want 1", in_ready);
    end
    model_clear();
  endtask

  task automatic test_defaults();
    rec_t e, g;
    drive(1'b1, 2, 8'h55);
    drain(30);
    n_cmp++;
    if (got_q.size() != 1) begin
      n_err++; $display("FAIL defaults_count: got %0d want 1", got_q.size());
    end else begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_cmp++;
      if (g.ch != 2 || g.len != 3 || g.anom != 1'b0 || e.len != 3) begin
        n_err++; $display("FAIL defaults_result: got ch%0d len%0d an%0d want ch2 len3 an0", g.ch, g.len, g.anom);
      end
      n_cmp++;
      if (g.cyc - e.cyc != 6) begin
        n_err++; $display("FAIL defaults_latency: got %0d want 6", g.cyc - e.cyc);
      end
    end
    step();
    n_cmp++;
    if (anomaly_flags !== 4'b0) begin
      n_err++; $display("FAIL defaults_flags: got %b want 0000", anomaly_flags);
    end
  endtask

  task automatic test_config();
    rec_t g;
    cfg_write(0, 8'h80, 1'b0);
    m_thr[0] = 8'h80; m_leaf[0] = 1'b0;
    n_cmp++;
    if (cfg_err !== 1'b0) begin n_err++; $display("FAIL cfg_ok_err0: got %b want 0", cfg_err); end
    cfg_write(1, 8'h00, 1'b1);
    m_thr[1] = 8'h00; m_leaf[1] = 1'b1;
    n_cmp++;
    if (cfg_err !== 1'b0) begin n_err++; $display("FAIL cfg_ok_err1: got %b want 0", cfg_err); end
    drive(1'b1, 1, 8'h10);
    drain(30);
    n_cmp++;
    if (got_q.size() != 1) begin
      n_err++; $display("FAIL cfg_anom_count: got %0d want 1", got_q.size());
    end else begin
      g = got_q.pop_front(); void'(exp_q.pop_front());
      n_cmp++;
      if (g.ch != 1 || g.len != 1 || g.anom != 1'b1) begin
        n_err++; $display("FAIL cfg_anom_result: got ch%0d len%0d an%0d want ch1 len1 an1", g.ch, g.len, g.anom);
      end
    end
    step();
    n_cmp++;
    if (anomaly_flags !== 4'b0010) begin
      n_err++; $display("FAIL cfg_anom_flags: got %b want 0010", anomaly_flags);
    end
    drive(1'b1, 0, 8'h90);
    drain(30);
    n_cmp++;
    if (got_q.size() != 1) begin
      n_err++; $display("FAIL cfg_right_count: got %0d want 1", got_q.size());
    end else begin
      g = got_q.pop_front(); void'(exp_q.pop_front());
      n_cmp++;
      if (g.ch != 0 || g.len != 3 || g.anom != 1'b0) begin
        n_err++; $display("FAIL cfg_right_result: got ch%0d len%0d an%0d want ch0 len3 an0", g.ch, g.len, g.anom);
      end
    end
  endtask

  task automatic compare_queues(input string tag);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL %s_count: got %0d want %0d", tag, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i].ch != exp_q[i].ch || got_q[i].len != exp_q[i].len || got_q[i].anom != exp_q[i].anom) begin
        n_err++;
        $display("FAIL %s_item%0d: got ch%0d len%0d an%0d want ch%0d len%0d an%0d", tag, i,
                 got_q[i].ch, got_q[i].len, got_q[i].anom, exp_q[i].ch, exp_q[i].len, exp_q[i].anom);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_fifo_fill();
    bit fell = 1'b0;
    int acc;
    do_reset();
    for (int i = 0; i < NUM_NODES; i++) begin
      m_thr[i] = 8'($urandom_range(0, 255));
      m_leaf[i] = ($urandom_range(0, 3) == 0);
      cfg_write(i, int'(m_thr[i]), m_leaf[i]);
      n_cmp++;
      if (cfg_err !== 1'b0) begin n_err++; $display("FAIL fill_cfg%0d: got %b want 0", i, cfg_err); end
    end
    for (int k = 0; k < 40 && !fell; k++) begin
      drive(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
      if (in_ready === 1'b0) fell = 1'b1;
    end
    acc = exp_q.size();
    n_cmp++;
    if (!fell || acc < FDEPTH) begin
      n_err++; $display("FAIL fill_backpressure: fell %0d accepts %0d want fell 1 accepts>=%0d", fell, acc, FDEPTH);
    end
    drain(400);
    compare_queues("fill");
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++)
      drive($urandom_range(0, 1) == 1, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
    drain(600);
    compare_queues("random");
  endtask

  task automatic test_cfg_busy();
    rec_t g;
    int k;
    do_reset();
    cfg_write(0, 8'h80, 1'b0); m_thr[0] = 8'h80;
    cfg_write(1, 8'h00, 1'b1); m_leaf[1] = 1'b1;
    drive(1'b1, 1, 8'h10);
    step();
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL busy_walk: got %b want 1", busy); end
    cfg_write(0, 8'h00, 1'b1);
    n_cmp++;
    if (cfg_err !== 1'b1) begin n_err++; $display("FAIL busy_cfg_err: got %b want 1", cfg_err); end
    k = 0;
    while (got_q.size() == 0 && k < 30) begin step(); k++; end
    flags_clear = 4'b0010;
    step();
    flags_clear = 4'b0000;
    n_cmp++;
    if (anomaly_flags[1] !== 1'b1) begin
      n_err++; $display("FAIL set_beats_clear: got %b want 1", anomaly_flags[1]);
    end
    compare_queues("busy_first");
    flags_clear = 4'b0010;
    step();
    flags_clear = 4'b0000;
    n_cmp++;
    if (anomaly_flags !== 4'b0000) begin
      n_err++; $display("FAIL clear_alone: got %b want 0000", anomaly_flags);
    end
    drive(1'b1, 0, 8'h90);
    drain(30);
    n_cmp++;
    if (got_q.size() != 1) begin
      n_err++; $display("FAIL busy_unchanged_count: got %0d want 1", got_q.size());
    end else begin
      g = got_q.pop_front(); void'(exp_q.pop_front());
      n_cmp++;
      if (g.len != 3) begin n_err++; $display("FAIL busy_unchanged_len: got %0d want 3", g.len); end
    end
    cfg_write(15, 8'h11, 1'b1);
    n_cmp++;
    if (cfg_err !== 1'b1) begin n_err++; $display("FAIL bad_addr_err: got %b want 1", cfg_err); end
    step();
    n_cmp++;
    if (cfg_err !== 1'b0) begin n_err++; $display("FAIL cfg_err_pulse: got %b want 0", cfg_err); end
  endtask

  task automatic test_reset_walk();
    drive(1'b1, 3, 8'h20);
    drive(1'b1, 2, 8'h30);
    step();
    reset = 1'b1;
    step();
    n_cmp++;
    if ({in_ready, res_valid, res_ch, res_path_len, res_anomaly, cfg_err, busy, anomaly_flags} !== 13'b0) begin
      n_err++;
      $display("FAIL walk_reset_outputs: got %b want 0", {in_ready, res_valid, res_ch, res_path_len,
               res_anomaly, cfg_err, busy, anomaly_flags});
    end
    reset = 1'b0;
    exp_q.delete(); got_q.delete();
    for (int k = 0; k < 12; k++) step();
    n_cmp++;
    if (got_q.size() != 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL walk_reset_discard: got results %0d busy %b want 0 0", got_q.size(), busy);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL walk_reset_ready: got %b want 1", in_ready); end
    model_clear();
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_config();
    test_fifo_fill();
    test_random();
    test_cfg_busy();
    test_reset_walk();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i_tree_multich.md
I_TREE_MULTICH -- requirements
Module: i_tree_multich

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_W, 8, sample width.
- NUM_CH, 4, sensor channel count (>=2).
- FIFO_DEPTH, 8, input buffer entries (power of 2).
- TREE_DEPTH, 4, tree levels; nodes = 2^TREE_DEPTH-1.
- ANOM_LEN, 2, path length strictly below which a sample is anomalous.

REQ-002 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk, in, 1, sole clock.
- reset, in, 1, synchronous active-high reset.
- in_valid, in, 1, sample offered.
- in_ready, out, 1, buffer can accept.
- in_ch, in, clog2(NUM_CH), channel of the sample.
- in_data, in, DATA_W, sample value.
- cfg_we, in, 1, node config write.
- cfg_addr, in, TREE_DEPTH, node index.
- cfg_thr, in, DATA_W, node split threshold.
- cfg_leaf, in, 1, node is a leaf.
- cfg_err, out, 1, one-cycle pulse when a write is dropped.
- res_valid, out, 1, one-cycle result strobe.
- res_ch, out, clog2(NUM_CH), channel of the result.
- res_path_len, out, clog2(TREE_DEPTH), edges traversed.
- res_anomaly, out, 1, res_path_len < ANOM_LEN.
- anomaly_flags, out, NUM_CH, sticky per-channel anomaly.
- flags_clear, in, NUM_CH, per-channel flag clear.
- busy, out, 1, evaluator not IDLE.

Function
REQ-003 A sample SHALL be accepted on an edge where in_valid && in_ready; {in_ch, in_data} is written to the FIFO.
REQ-004 in_ready SHALL equal !fifo_full; a simultaneous pop SHALL NOT make a full FIFO accept in that cycle.
REQ-005 The FIFO SHALL not bypass: an accepted sample is visible to the evaluator no earlier than the next cycle.
REQ-006 The evaluator FSM SHALL have three states:
- IDLE: pops when the FIFO is non-empty, registers the sample and channel, sets node=0 and len=0, goes to WALK.
- WALK: one node per cycle.
- DONE: drives res_* with res_valid=1 for one cycle, then returns to IDLE.
REQ-007 In WALK at node n:
- If leaf[n]=1 or n lies at level TREE_DEPTH-1, the FSM SHALL go to DONE with len unchanged.
- Otherwise it SHALL move to 2n+1 if sample < thr[n] (unsigned), else to 2n+2, and increment len.
REQ-008 Latency from the accepting edge to res_valid, with the evaluator idle and the FIFO empty, SHALL be res_path_len+3 cycles.
REQ-009 Throughput SHALL be one sample per (res_path_len+3) cycles; back-to-back samples queue in the FIFO in arrival order.
REQ-010 On res_valid && res_anomaly, anomaly_flags[res_ch] SHALL set in the next cycle.
REQ-011 flags_clear[i] SHALL clear anomaly_flags[i]; a simultaneous set on the same channel SHALL win.
REQ-012 Config writes:
- Accepted only when busy=0 (FSM in IDLE).
- Writes while busy, or with cfg_addr >= 2^TREE_DEPTH-1, SHALL be dropped and pulse cfg_err the next cycle.
- An accepted write SHALL affect only samples popped afterwards.
REQ-013 All arithmetic SHALL be unsigned; len SHALL never exceed TREE_DEPTH-1.

Reset
REQ-014 reset SHALL be sampled only on rising clk.
REQ-015 During reset the block SHALL:
- Empty the FIFO and return the FSM to IDLE.
- Set all thr to 0 and all leaf bits to 0.
- Drive in_ready=0, res_valid=0, res_ch=0, res_path_len=0, res_anomaly=0, anomaly_flags=0, cfg_err=0, busy=0.
REQ-016 in_ready SHALL be 1 the cycle after reset deasserts.
REQ-017 Reset mid-WALK SHALL discard the in-flight sample with no res_valid.

Structure
REQ-018 Package i_tree_pkg SHALL hold the FSM state enum, default parameter values and the node child-index function.
REQ-019 The FIFO SHALL be a sub-module i_tree_fifo (parametrised width/depth, full/empty, synchronous reset); node tables are arrays local to i_tree_multich.

Verification
REQ-020 The bench SHALL cover these directed scenarios (stimulus -> required response):
- After reset, defaults: ch2 data 0x55 -> res_valid 6 cycles later, res_ch=2, res_path_len=3, res_anomaly=0, anomaly_flags=0.
- Config node0 thr=0x80, node1 leaf=1; ch1 data 0x10 -> res_path_len=1, res_anomaly=1, anomaly_flags=4'b0010.
- Same config; ch0 data 0x90 -> res_path_len=3, res_anomaly=0.
- Hold in_valid with the evaluator stalled for 9 cycles after reset -> in_ready falls after 8 accepts; results emerge in order; no sample lost or duplicated.
- cfg_we while busy=1 -> cfg_err pulse, thresholds unchanged; flags_clear[1] with a coincident ch1 anomaly -> flag stays 1.
- Assert reset during WALK -> no res_valid; FIFO empty; all outputs at reset values.
